// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between a data master (M0) and an instruction master (M1).
// One transaction at a time. Every completion is followed by an IDLE bubble.
module ram_arbiter #(
  parameter int ADDR_BITS = 13,
  parameter int N_BYTES   = 4,
  parameter int N_BITS    = N_BYTES * 8,
  parameter bit RR_EN     = 1'b1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [N_BITS-1:0]    m0_wdata,
  input  logic [N_BYTES-1:0]   m0_byte_en,
  input  logic                 m0_ren,
  input  logic                 m0_wen,
  output logic [N_BITS-1:0]    m0_rdata,
  output logic                 m0_busy,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [N_BITS-1:0]    m1_wdata,
  input  logic [N_BYTES-1:0]   m1_byte_en,
  input  logic                 m1_ren,
  input  logic                 m1_wen,
  output logic [N_BITS-1:0]    m1_rdata,
  output logic                 m1_busy,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [N_BITS-1:0]    ram_wdata,
  output logic [N_BYTES-1:0]   ram_byte_en,
  output logic                 ram_ren,
  output logic                 ram_wen,
  input  logic [N_BITS-1:0]    ram_rdata,
  input  logic                 ram_busy
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   last_grant;
  logic   m0_req;
  logic   m1_req;

  assign m0_req = m0_ren | m0_wen;
  assign m1_req = m1_ren | m1_wen;

  // last_grant resets to 1 so that M0 wins the first contention
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req && m1_req)
            state <= (RR_EN && (last_grant == 1'b0)) ? GNT1 : GNT0;
          else if (m0_req)
            state <= GNT0;
          else if (m1_req)
            state <= GNT1;
        end
        GNT0: begin
          if (!m0_req) begin
            state <= IDLE;
          end else if (!ram_busy) begin
            last_grant <= 1'b0;
            state      <= IDLE;
          end
        end
        GNT1: begin
          if (!m1_req) begin
            state <= IDLE;
          end else if (!ram_busy) begin
            last_grant <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The granted master drives the RAM directly. A write wins over a simultaneous read.
  always_comb begin
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_byte_en = '0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    m0_busy     = 1'b1;
    m1_busy     = 1'b1;
    m0_rdata    = '0;
    m1_rdata    = '0;
    case (state)
      GNT0: begin
        ram_addr    = m0_addr;
        ram_wdata   = m0_wdata;
        ram_byte_en = m0_byte_en;
        ram_wen     = m0_wen;
        ram_ren     = m0_ren & ~m0_wen;
        if (m0_req && !ram_busy) begin
          m0_busy  = 1'b0;
          m0_rdata = ram_rdata;
        end
      end
      GNT1: begin
        ram_addr    = m1_addr;
        ram_wdata   = m1_wdata;
        ram_byte_en = m1_byte_en;
        ram_wen     = m1_wen;
        ram_ren     = m1_ren & ~m1_wen;
        if (m1_req && !ram_busy) begin
          m1_busy  = 1'b0;
          m1_rdata = ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
